// File: rtl/fht_bfly_inv_ser.sv
// -----------------------------------------------------------------------------
// fht_bfly_inv_ser
// Inverse Hadamard butterfly with serialised output. Each accepted pair (c, d)
// with c = a+b and d = a-b is turned back into the two samples
// a = (c+d)>>>1 and b = (c-d)>>>1. These are emitted one per handshake: a first
// (out_sel=0), then b (out_sel=1).
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   a (c, d) pair is offered
//   in_ready   pair is taken this cycle (combinational; follows out_ready in OUT_B)
//   c, d       N+1 bit two's-complement butterfly terms
//   out_valid  out_data holds a sample
//   out_ready  consumer takes out_data this cycle
//   out_data   N bit reconstructed sample
//   out_sel    0 = sample a, 1 = sample b
//   err        sticky flags: [0] parity (c[0]!=d[0]), [1] result out of N-bit range
//   err_clr    synchronous clear of err (a coincident new error still sets)
// -----------------------------------------------------------------------------
module fht_bfly_inv_ser #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N:0]   c,
  input  logic [N:0]   d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sel,
  output logic [1:0]   err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OUT_A = 2'd1,
    OUT_B = 2'd2
  } state_t;

  state_t              state_r;
  logic [N-1:0]        b_r;
  logic [N-1:0]        out_data_r;
  logic                out_valid_r;
  logic                out_sel_r;
  logic [1:0]          err_r;

  logic signed [N+1:0] c_ext_s;
  logic signed [N+1:0] d_ext_s;
  logic signed [N+1:0] sum_s;
  logic signed [N+1:0] dif_s;
  logic signed [N+1:0] a_full_s;
  logic signed [N+1:0] b_full_s;
  logic                accept_s;
  logic [1:0]          new_err_s;

  // A genuine butterfly output has c and d of equal parity.
  function automatic logic parity_err(input logic c_lsb, input logic d_lsb);
    return c_lsb ^ d_lsb;
  endfunction

  // After the 1-bit shift, bit N+1 always equals bit N. The value fits in N
  // signed bits only when the top three bits agree.
  function automatic logic range_err(input logic [N+1:0] v);
    return !((&v[N+1:N-1]) || (~|v[N+1:N-1]));
  endfunction

  // Reconstruction datapath at N+2 bits so that c+d and c-d never overflow.
  always_comb begin
    c_ext_s  = signed'({c[N], c});
    d_ext_s  = signed'({d[N], d});
    sum_s    = c_ext_s + d_ext_s;
    dif_s    = c_ext_s - d_ext_s;
    a_full_s = sum_s >>> 1;
    b_full_s = dif_s >>> 1;
    new_err_s = {range_err(a_full_s) | range_err(b_full_s), parity_err(c[0], d[0])};
  end

  // Ready depends on the state. In OUT_B it passes out_ready straight through,
  // so a new pair can load in the same cycle that b is consumed.
  always_comb begin
    case (state_r)
      IDLE:    in_ready = 1'b1;
      OUT_A:   in_ready = 1'b0;
      OUT_B:   in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Acceptance is the input handshake.
  always_comb begin
    accept_s = in_valid & in_ready;
  end

  // Output FSM. a goes directly into the output register and b waits in b_r.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_sel_r   <= 1'b0;
      out_data_r  <= '0;
      b_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r     <= OUT_A;
            out_valid_r <= 1'b1;
            out_sel_r   <= 1'b0;
            out_data_r  <= a_full_s[N-1:0];
            b_r         <= b_full_s[N-1:0];
          end
        end
        OUT_A: begin
          if (out_ready) begin
            state_r    <= OUT_B;
            out_sel_r  <= 1'b1;
            out_data_r <= b_r;
          end
        end
        OUT_B: begin
          if (out_ready) begin
            if (accept_s) begin
              state_r     <= OUT_A;
              out_valid_r <= 1'b1;
              out_sel_r   <= 1'b0;
              out_data_r  <= a_full_s[N-1:0];
              b_r         <= b_full_s[N-1:0];
            end else begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_sel_r   <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_sel_r   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags. A new error takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_r <= 2'b00;
    end else begin
      err_r <= (err_clr ? 2'b00 : err_r) | (accept_s ? new_err_s : 2'b00);
    end
  end

  assign out_valid = out_valid_r;
  assign out_sel   = out_sel_r;
  assign out_data  = out_data_r;
  assign err       = err_r;

endmodule
